// File: rtl/sort_stream_io_if.sv
// sort_stream_io_if: input stream, sorter handshake, RAM port and sorted output stream
// of sort_stream_io. The block connects through "master"; its environment uses "slave".
interface sort_stream_io_if #(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_DATA = 8
) ();
  logic                 i_in_valid;
  logic                 o_in_ready;
  logic [SIZE_DATA-1:0] i_in_data;
  logic                 i_in_last;
  logic                 o_sort_start;
  logic                 i_sort_done;
  logic [SIZE_ADDR-1:0] o_num_elems;
  logic                 o_ram_grant;
  logic                 o_ram_wr_en;
  logic                 o_ram_rd_en;
  logic [SIZE_ADDR-1:0] o_ram_addr;
  logic [SIZE_DATA-1:0] o_ram_wr_data;
  logic [SIZE_DATA-1:0] i_ram_rd_data;
  logic                 o_out_valid;
  logic                 i_out_ready;
  logic [SIZE_DATA-1:0] o_out_data;
  logic                 o_out_last;
  logic                 o_overflow;

  modport master (
    input  i_in_valid, i_in_data, i_in_last, i_sort_done, i_ram_rd_data, i_out_ready,
    output o_in_ready, o_sort_start, o_num_elems, o_ram_grant, o_ram_wr_en, o_ram_rd_en,
           o_ram_addr, o_ram_wr_data, o_out_valid, o_out_data, o_out_last, o_overflow
  );

  modport slave (
    output i_in_valid, i_in_data, i_in_last, i_sort_done, i_ram_rd_data, i_out_ready,
    input  o_in_ready, o_sort_start, o_num_elems, o_ram_grant, o_ram_wr_en, o_ram_rd_en,
           o_ram_addr, o_ram_wr_data, o_out_valid, o_out_data, o_out_last, o_overflow
  );
endinterface

// File: rtl/sort_stream_io.sv
// sort_stream_io: loads a frame into an external RAM, hands the RAM to a sorter, then streams
// the sorted frame out. Define SORT_STREAM_DESC_EN to unload in descending address order.
module sort_stream_io #(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_DATA = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  sort_stream_io_if.master bus
);

  typedef enum logic [1:0] {LOAD, START, SORT, UNLOAD} state_t;

  localparam logic [SIZE_ADDR-1:0] MAX_M1 = {{(SIZE_ADDR-1){1'b1}}, 1'b0};

  state_t               state_q, state_d;
  logic [SIZE_ADDR-1:0] count_q;
  logic                 load_done_q;
  logic                 overflow_q;
  logic [SIZE_ADDR-1:0] rd_idx_q;

  logic                 wr_vld_p0;
  logic [SIZE_ADDR-1:0] wr_addr_p0;
  logic [SIZE_DATA-1:0] wr_data_p0;

  logic                 rd_vld_p0;
  logic                 rd_last_p0;

  logic [SIZE_DATA-1:0] fifo_data [2];
  logic                 fifo_last [2];
  logic                 fifo_wp, fifo_rp;
  logic [1:0]           fifo_occ;

  logic                 in_ready, sort_start, grant;
  logic                 acc, out_valid, out_fire, last_fire;
  logic [1:0]           occ_after;
  logic                 rd_issue, rd_last, wr_en;
  logic [SIZE_ADDR-1:0] rd_addr;

  assign acc       = bus.i_in_valid && in_ready;
  assign out_valid = (fifo_occ != 2'd0) && !i_rst;
  assign out_fire  = out_valid && bus.i_out_ready;
  assign last_fire = out_fire && fifo_last[fifo_rp];
  assign wr_en     = wr_vld_p0 && !i_rst;

  // Read admission counts the slot freed by this cycle's pop, so a steady
  // pop/read/return overlap sustains one beat per cycle.
  assign occ_after = fifo_occ - 2'(out_fire);
  assign rd_issue  = (state_q == UNLOAD) && !i_rst && (rd_idx_q < count_q) &&
                     ((occ_after == 2'd0) || ((occ_after == 2'd1) && !rd_vld_p0));
  assign rd_last   = (rd_idx_q == count_q - SIZE_ADDR'(1));
`ifdef SORT_STREAM_DESC_EN
  assign rd_addr   = count_q - SIZE_ADDR'(1) - rd_idx_q;
`else
  assign rd_addr   = rd_idx_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    sort_start = 1'b0;
    grant      = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = !load_done_q && !i_rst;
        if (load_done_q) state_d = (count_q > SIZE_ADDR'(1)) ? START : UNLOAD;
      end
      START: begin
        sort_start = !i_rst;
        state_d    = SORT;
      end
      SORT: begin
        grant = 1'b1;
        if (bus.i_sort_done) state_d = UNLOAD;
      end
      UNLOAD: begin
        if (last_fire) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q     <= '0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      rd_idx_q    <= '0;
      wr_vld_p0   <= 1'b0;
      rd_vld_p0   <= 1'b0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_occ    <= 2'd0;
    end else begin
      wr_vld_p0 <= acc;
      rd_vld_p0 <= rd_issue;
      if (acc) begin
        count_q    <= count_q + SIZE_ADDR'(1);
        overflow_q <= (count_q == MAX_M1) && !bus.i_in_last;
        if (bus.i_in_last || (count_q == MAX_M1)) load_done_q <= 1'b1;
      end
      if (rd_issue) rd_idx_q <= rd_idx_q + SIZE_ADDR'(1);
      if (rd_vld_p0) fifo_wp <= ~fifo_wp;
      if (out_fire)  fifo_rp <= ~fifo_rp;
      case ({rd_vld_p0, out_fire})
        2'b10:   fifo_occ <= fifo_occ + 2'd1;
        2'b01:   fifo_occ <= fifo_occ - 2'd1;
        default: fifo_occ <= fifo_occ;
      endcase
      if (last_fire) begin
        count_q     <= '0;
        load_done_q <= 1'b0;
        rd_idx_q    <= '0;
      end
    end
  end

  // p0: accepted beat -> RAM write; read issue -> RAM data returning into the FIFO
  always_ff @(posedge i_clk) begin
    if (acc) begin
      wr_addr_p0 <= count_q;
      wr_data_p0 <= bus.i_in_data;
    end
    if (rd_issue) rd_last_p0 <= rd_last;
    if (rd_vld_p0) begin
      fifo_data[fifo_wp] <= bus.i_ram_rd_data;
      fifo_last[fifo_wp] <= rd_last_p0;
    end
  end

  assign bus.o_in_ready    = in_ready;
  assign bus.o_sort_start  = sort_start;
  assign bus.o_ram_grant   = grant;
  assign bus.o_num_elems   = count_q;
  assign bus.o_overflow    = overflow_q;
  assign bus.o_ram_wr_en   = wr_en;
  assign bus.o_ram_rd_en   = rd_issue;
  assign bus.o_ram_addr    = wr_en ? wr_addr_p0 : (rd_issue ? rd_addr : '0);
  assign bus.o_ram_wr_data = wr_en ? wr_data_p0 : '0;
  assign bus.o_out_valid   = out_valid;
  assign bus.o_out_data    = out_valid ? fifo_data[fifo_rp] : '0;
  assign bus.o_out_last    = out_valid && fifo_last[fifo_rp];

endmodule

// File: tb/tb_sort_stream_io.sv
// tb_sort_stream_io: directed frames against sort_stream_io with a behavioural RAM and sorter.
// Expected output orders follow SORT_STREAM_DESC_EN when the bench is built with it.
module tb_sort_stream_io;
  localparam int SIZE_ADDR = 8;
  localparam int SIZE_DATA = 8;
`ifdef SORT_STREAM_DESC_EN
  localparam bit DESC = 1'b1;
`else
  localparam bit DESC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tog_en = 1'b0;
  logic tog = 1'b1;
  always #5 clk = ~clk;

  sort_stream_io_if #(.SIZE_ADDR(SIZE_ADDR), .SIZE_DATA(SIZE_DATA)) bus ();
  sort_stream_io #(.SIZE_ADDR(SIZE_ADDR), .SIZE_DATA(SIZE_DATA)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always @(posedge clk) tog <= ~tog;
  assign bus.i_out_ready = tog_en ? tog : 1'b1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural RAM (1-cycle read) and sorter that answers a start pulse a few cycles later.
  logic [7:0] mem [256];
  initial begin : ram_model
    int sort_cnt;
    int n;
    logic [7:0] tmp;
    sort_cnt = 0;
    bus.i_sort_done = 1'b0;
    bus.i_ram_rd_data = '0;
    forever begin
      @(posedge clk);
      bus.i_sort_done <= 1'b0;
      if (bus.o_ram_rd_en) bus.i_ram_rd_data <= mem[bus.o_ram_addr];
      if (bus.o_ram_wr_en) mem[bus.o_ram_addr] = bus.o_ram_wr_data;
      if (rst) sort_cnt = 0;
      else if (bus.o_sort_start) begin
        n = int'(bus.o_num_elems);
        for (int i = 0; i < n - 1; i++)
          for (int j = 0; j < n - 1 - i; j++)
            if (mem[j] > mem[j+1]) begin
              tmp = mem[j]; mem[j] = mem[j+1]; mem[j+1] = tmp;
            end
        sort_cnt = 3;
      end else if (sort_cnt > 0) begin
        sort_cnt--;
        if (sort_cnt == 0) bus.i_sort_done <= 1'b1;
      end
    end
  end

  logic [7:0] outq [$];
  logic       lastq [$];
  int         outcyc [$];
  int         wr_addrq [$];
  int last_wr_cyc = 0, n_rd = 0, n_coll = 0, n_start = 0, start_cyc = 0;
  int n_grant = 0, done_cyc = 0, n_stall = 0, n_stall_err = 0;
  logic       stall_prev = 1'b0;
  logic [8:0] stall_val = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) stall_prev = 1'b0;
      else begin
        if (bus.o_ram_wr_en) begin
          wr_addrq.push_back(int'(bus.o_ram_addr));
          last_wr_cyc = cyc;
        end
        if (bus.o_ram_rd_en) n_rd++;
        if (bus.o_ram_wr_en && bus.o_ram_rd_en) n_coll++;
        if (bus.o_sort_start) begin n_start++; start_cyc = cyc; end
        if (bus.o_ram_grant) begin
          n_grant++;
          if (bus.i_sort_done) done_cyc = cyc;
        end
        if (stall_prev) begin
          n_stall++;
          if ({bus.o_out_last, bus.o_out_data} !== stall_val || !bus.o_out_valid) n_stall_err++;
        end
        stall_prev = bus.o_out_valid && !bus.i_out_ready;
        stall_val  = {bus.o_out_last, bus.o_out_data};
        if (bus.o_out_valid && bus.i_out_ready) begin
          outq.push_back(bus.o_out_data);
          lastq.push_back(bus.o_out_last);
          outcyc.push_back(cyc);
        end
      end
    end
  end

  logic [7:0] frame_q [$];

  // Called just after a rising edge; drives one beat at a time until accepted or max_wait cycles.
  task automatic send_frame(input bit use_last, input int max_wait, output int acc);
    int n;
    bit got;
    n = frame_q.size();
    acc = 0;
    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      bus.i_in_valid = 1'b1;
      bus.i_in_data  = frame_q[i];
      bus.i_in_last  = use_last && (i == n - 1);
      for (int k = 0; k < max_wait && !got; k++) begin
        @(negedge clk);
        got = bus.o_in_ready;
        @(posedge clk); #1;
      end
      if (!got) break;
      acc++;
    end
    bus.i_in_valid = 1'b0;
    bus.i_in_last  = 1'b0;
    bus.i_in_data  = '0;
  endtask

  task automatic wait_out(input string tag, input int n);
    int t;
    t = 0;
    while (outq.size() < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk({tag, "_done"}, 32'(outq.size() >= n), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string tag, input int b, input int n, input logic [7:0] e0,
                         input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3,
                         input logic [7:0] e4);
    logic [7:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    chk({tag, "_count"}, 32'(outq.size() - b), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(outq[b+i]), 32'(e[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(lastq[b+i]), 32'(i == n - 1));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc, b, w, s0, g0, st0, r0, nl, a;
    logic [7:0] e;
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = '0;
    bus.i_in_last  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(bus.o_in_ready), 0);
    chk("rst_out_valid", 32'(bus.o_out_valid), 0);
    chk("rst_outs", 32'({bus.o_sort_start, bus.o_ram_grant, bus.o_ram_wr_en, bus.o_ram_rd_en,
                        bus.o_out_last, bus.o_overflow}), 0);
    chk("rst_num_elems", 32'(bus.o_num_elems), 0);
    chk("rst_addr_data", 32'({bus.o_ram_addr, bus.o_ram_wr_data, bus.o_out_data}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(bus.o_in_ready), 1);
    @(posedge clk); #1;

    // Five-element frame, downstream always ready
    frame_q = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5};
    b = outq.size(); w = wr_addrq.size(); s0 = n_start;
    send_frame(1'b1, 8, acc);
    chk("f5_accepted", 32'(acc), 5);
    @(negedge clk);
    chk("f5_num_elems", 32'(bus.o_num_elems), 5);
    wait_out("f5", b + 5);
    if (DESC) chk_seq("f5", b, 5, 5, 4, 3, 1, 1);
    else      chk_seq("f5", b, 5, 1, 1, 3, 4, 5);
    chk("f5_writes", 32'(wr_addrq.size() - w), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("f5_wr_addr%0d", i), 32'(wr_addrq[w+i]), 32'(i));
    chk("f5_start_pulses", 32'(n_start - s0), 1);
    chk("f5_start_timing", 32'(start_cyc), 32'(last_wr_cyc + 1));
    chk("f5_first_out", 32'(outcyc[b]), 32'(done_cyc + 3));
    chk("f5_back_to_back", 32'(outcyc[b+4] - outcyc[b]), 4);
    @(negedge clk);
    chk("f5_num_elems_clr", 32'(bus.o_num_elems), 0);
    chk("f5_ready_again", 32'(bus.o_in_ready), 1);
    @(posedge clk); #1;

    // Single-beat frame bypasses the sorter
    frame_q = '{8'd7};
    b = outq.size(); s0 = n_start; g0 = n_grant;
    send_frame(1'b1, 8, acc);
    wait_out("f1", b + 1);
    chk("f1_data", 32'(outq[b]), 7);
    chk("f1_last", 32'(lastq[b]), 1);
    chk("f1_no_start", 32'(n_start - s0), 0);
    chk("f1_no_grant", 32'(n_grant - g0), 0);
    chk("f1_latency", 32'(outcyc[b]), 32'(last_wr_cyc + 3));

    // 256 beats without last: the 256th must be refused
    frame_q.delete();
    for (int i = 0; i < 256; i++) frame_q.push_back(8'(i) ^ 8'hA5);
    b = outq.size(); w = wr_addrq.size();
    send_frame(1'b0, 3, acc);
    chk("ovf_accepted", 32'(acc), 255);
    @(negedge clk);
    chk("ovf_flag", 32'(bus.o_overflow), 1);
    chk("ovf_in_ready", 32'(bus.o_in_ready), 0);
    chk("ovf_num_elems", 32'(bus.o_num_elems), 255);
    wait_out("ovf", b + 255);
    chk("ovf_writes", 32'(wr_addrq.size() - w), 255);
    chk("ovf_count", 32'(outq.size() - b), 255);
    nl = 0;
    for (int k = 0; k < 255; k++) begin
      a = DESC ? 254 - k : k;
      e = (a < 'h5A) ? 8'(a) : 8'(a + 1);
      chk($sformatf("ovf_data%0d", k), 32'(outq[b+k]), 32'(e));
      nl += int'(lastq[b+k]);
    end
    chk("ovf_single_last", 32'(nl), 1);
    chk("ovf_last_pos", 32'(lastq[b+254]), 1);
    chk("ovf_sticky", 32'(bus.o_overflow), 1);

    // Same five-element frame with downstream ready toggling every cycle
    tog_en = 1'b1;
    frame_q = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5};
    b = outq.size(); st0 = n_stall;
    send_frame(1'b1, 8, acc);
    chk("tog_ovf_cleared", 32'(bus.o_overflow), 0);
    wait_out("tog", b + 5);
    if (DESC) chk_seq("tog", b, 5, 5, 4, 3, 1, 1);
    else      chk_seq("tog", b, 5, 1, 1, 3, 4, 5);
    chk("tog_stalls_seen", 32'(n_stall > st0), 1);
    chk("tog_stall_stable", 32'(n_stall_err), 0);
    tog_en = 1'b0;
    @(posedge clk); #1;

    // Reset pulse in the middle of unloading, then a fresh three-element frame
    frame_q = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5};
    b = outq.size();
    send_frame(1'b1, 8, acc);
    a = 0;
    while (outq.size() < b + 2 && a < 200) begin
      @(posedge clk);
      a++;
    end
    chk("mid_reached_unload", 32'(outq.size() >= b + 2), 1);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", 32'(bus.o_out_valid), 0);
    chk("mid_num_elems", 32'(bus.o_num_elems), 0);
    chk("mid_in_ready", 32'(bus.o_in_ready), 1);
    b = outq.size(); w = wr_addrq.size(); r0 = n_rd;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("mid_no_beats", 32'(outq.size() - b), 0);
    chk("mid_no_strobes", 32'((wr_addrq.size() - w) + (n_rd - r0)), 0);
    @(posedge clk); #1;
    frame_q = '{8'd9, 8'd2, 8'd5};
    b = outq.size();
    send_frame(1'b1, 8, acc);
    wait_out("f3", b + 3);
    chk("f3_count", 32'(outq.size() - b), 3);
    if (DESC) begin
      chk("f3_d0", 32'(outq[b]), 9); chk("f3_d1", 32'(outq[b+1]), 5); chk("f3_d2", 32'(outq[b+2]), 2);
    end else begin
      chk("f3_d0", 32'(outq[b]), 2); chk("f3_d1", 32'(outq[b+1]), 5); chk("f3_d2", 32'(outq[b+2]), 9);
    end
    chk("f3_lasts", 32'({lastq[b], lastq[b+1], lastq[b+2]}), 32'b001);

    chk("rw_exclusive", 32'(n_coll), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
